// File: rtl/keypad_if.sv
// Keypad-side and consumer-side signals of the keypad scanner.
// The scanner drives columns and key outputs and reads the rows.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_hex;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  row,
        output col,
        output key_hex,
        output key_valid,
        output key_down
    );

    modport slave (
        output row,
        input  col,
        input  key_hex,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with two-flop row synchronizer and scan-level debounce.
// Emits one key_valid pulse with the hex code per accepted press; no auto-repeat.
module keypad_scanner #(
    parameter int unsigned SCAN_CYCLES    = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);

    localparam int unsigned CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_MAX   = DEB_W'(DEBOUNCE_SCANS);
    localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_REL_WAIT
    } state_t;

    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_sync;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_col_idx;
    logic [3:0]       r_col;
    logic [1:0]       r_acc_hits;
    logic [3:0]       r_acc_key;

    state_t           r_state;
    state_t           w_state_nx;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_nx;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [DEB_W-1:0] w_deb_cnt_nx;
    logic [DEB_W-1:0] w_deb_inc;
    logic [3:0]       r_key_hex;
    logic [3:0]       w_key_hex_nx;
    logic             r_key_valid;
    logic             w_key_valid_nx;
    logic             r_key_down;
    logic             w_key_down_nx;

    logic             w_dwell_end;
    logic             w_scan_end;
    logic [1:0]       w_idx_nx;
    logic [3:0]       w_pressed;
    logic [2:0]       w_col_hits;
    logic [1:0]       w_col_row;
    logic [3:0]       w_col_key;
    logic [2:0]       w_sum;
    logic [1:0]       w_scan_hits;
    logic [3:0]       w_scan_key;
    logic             w_single;

    function automatic logic [3:0] f_key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] v;
        case ({r, c})
            4'h0: v = 4'h1;
            4'h1: v = 4'h2;
            4'h2: v = 4'h3;
            4'h3: v = 4'hA;
            4'h4: v = 4'h4;
            4'h5: v = 4'h5;
            4'h6: v = 4'h6;
            4'h7: v = 4'hB;
            4'h8: v = 4'h7;
            4'h9: v = 4'h8;
            4'hA: v = 4'h9;
            4'hB: v = 4'hC;
            4'hC: v = 4'h0;
            4'hD: v = 4'hF;
            4'hE: v = 4'hE;
            default: v = 4'hD;
        endcase
        return v;
    endfunction

    // Row synchronizer; idle (all rows high) on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= kp.row;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_dwell_end = (r_scan_cnt == SCAN_LAST);
    assign w_scan_end  = w_dwell_end && (r_col_idx == 2'd3);
    assign w_idx_nx    = r_col_idx + 2'd1;
    assign w_pressed   = ~r_row_sync;
    assign w_col_hits  = 3'(w_pressed[0]) + 3'(w_pressed[1])
                       + 3'(w_pressed[2]) + 3'(w_pressed[3]);

    always_comb begin
        case (w_pressed)
            4'b0010: w_col_row = 2'd1;
            4'b0100: w_col_row = 2'd2;
            4'b1000: w_col_row = 2'd3;
            default: w_col_row = 2'd0;
        endcase
    end

    // Hit count saturates at 2: anything beyond one key is a chord/ghost
    assign w_col_key   = f_key_map(w_col_row, r_col_idx);
    assign w_sum       = 3'(r_acc_hits) + w_col_hits;
    assign w_scan_hits = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
    assign w_scan_key  = (r_acc_hits == 2'd0) ? w_col_key : r_acc_key;
    assign w_single    = w_scan_end && (w_scan_hits == 2'd1);

    // Column dwell counter, column drive and per-scan hit accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_col_idx  <= 2'd0;
            r_col      <= 4'b1110;
            r_acc_hits <= 2'd0;
            r_acc_key  <= 4'h0;
        end else if (w_dwell_end) begin
            r_scan_cnt <= '0;
            r_col_idx  <= w_idx_nx;
            r_col      <= ~(4'b0001 << w_idx_nx);
            if (r_col_idx == 2'd3) begin
                r_acc_hits <= 2'd0;
                r_acc_key  <= 4'h0;
            end else begin
                r_acc_hits <= w_scan_hits;
                r_acc_key  <= w_scan_key;
            end
        end else begin
            r_scan_cnt <= r_scan_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cand      <= 4'h0;
            r_deb_cnt   <= '0;
            r_key_hex   <= 4'hF;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cand      <= w_cand_nx;
            r_deb_cnt   <= w_deb_cnt_nx;
            r_key_hex   <= w_key_hex_nx;
            r_key_valid <= w_key_valid_nx;
            r_key_down  <= w_key_down_nx;
        end
    end

    assign w_deb_inc = (r_deb_cnt == DEB_MAX) ? r_deb_cnt : r_deb_cnt + DEB_ONE;

    // Debounce decisions happen only on the cycle that samples column 3
    always_comb begin
        w_state_nx     = r_state;
        w_cand_nx      = r_cand;
        w_deb_cnt_nx   = r_deb_cnt;
        w_key_hex_nx   = r_key_hex;
        w_key_valid_nx = 1'b0;
        w_key_down_nx  = r_key_down;

        case (r_state)
            S_IDLE: begin
                if (w_single) begin
                    w_cand_nx    = w_scan_key;
                    w_deb_cnt_nx = DEB_ONE;
                    if (DEBOUNCE_SCANS == 1) begin
                        w_key_hex_nx   = w_scan_key;
                        w_key_valid_nx = 1'b1;
                        w_key_down_nx  = 1'b1;
                        w_state_nx     = S_HELD;
                    end else begin
                        w_state_nx = S_PRESS_WAIT;
                    end
                end
            end
            S_PRESS_WAIT: begin
                if (w_single) begin
                    if (w_scan_key == r_cand) begin
                        w_deb_cnt_nx = w_deb_inc;
                        if (w_deb_inc == DEB_MAX) begin
                            w_key_hex_nx   = r_cand;
                            w_key_valid_nx = 1'b1;
                            w_key_down_nx  = 1'b1;
                            w_state_nx     = S_HELD;
                        end
                    end else begin
                        w_cand_nx    = w_scan_key;
                        w_deb_cnt_nx = DEB_ONE;
                    end
                end else if (w_scan_end) begin
                    w_deb_cnt_nx = '0;
                    w_state_nx   = S_IDLE;
                end
            end
            S_HELD: begin
                if (w_scan_end && !w_single) begin
                    w_deb_cnt_nx = DEB_ONE;
                    if (DEBOUNCE_SCANS == 1) begin
                        w_key_down_nx = 1'b0;
                        w_state_nx    = S_IDLE;
                    end else begin
                        w_state_nx = S_REL_WAIT;
                    end
                end
            end
            S_REL_WAIT: begin
                if (w_single) begin
                    w_state_nx = S_HELD;
                end else if (w_scan_end) begin
                    w_deb_cnt_nx = w_deb_inc;
                    if (w_deb_inc == DEB_MAX) begin
                        w_key_down_nx = 1'b0;
                        w_state_nx    = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign kp.col       = r_col;
    assign kp.key_hex   = r_key_hex;
    assign kp.key_valid = r_key_valid;
    assign kp.key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model.
module tb_keypad_scanner;

    localparam int unsigned SC = 4;
    localparam int unsigned DB = 2;

    // Key index r*4+c -> expected hex code
    localparam int K1 = 0;
    localparam int KA = 3;
    localparam int K5 = 5;
    localparam int K7 = 8;
    localparam int K9 = 10;
    localparam int K0 = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys;
    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          n_pulses = 0;
    int          base;
    logic [3:0]  pulse_hex = 4'h0;
    logic [3:0]  exp_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'h0, 4'hF, 4'hE, 4'hD};

    keypad_if kp ();

    keypad_scanner #(
        .SCAN_CYCLES    (SC),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        kp.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) begin
            n_pulses  <= n_pulses + 1;
            pulse_hex <= kp.key_hex;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick(3);
        check({tag, "_col"},   32'(kp.col),       32'h0000000E);
        check({tag, "_hex"},   32'(kp.key_hex),   32'h0000000F);
        check({tag, "_valid"}, 32'(kp.key_valid), 32'h0);
        check({tag, "_down"},  32'(kp.key_down),  32'h0);
        rst = 1'b0;
    endtask

    // Returns just after column 0 of a new scan starts being driven
    task automatic align_scan();
        logic [3:0] prev;
        bit         found;
        prev  = kp.col;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (kp.col == 4'b1110 && prev == 4'b0111) found = 1'b1;
            prev = kp.col;
        end
        check("align_scan", 32'(found), 32'h1);
    endtask

    initial begin
        keys = 16'h0;

        // 1. Reset and column stepping
        do_reset("rst0");
        tick(1);  check("col_c0", 32'(kp.col), 32'hE);
        tick(3);  check("col_c1", 32'(kp.col), 32'hD);
        tick(4);  check("col_c2", 32'(kp.col), 32'hB);
        tick(4);  check("col_c3", 32'(kp.col), 32'h7);
        tick(4);  check("col_wrap", 32'(kp.col), 32'hE);

        // 2. Single press of '5', hold, release
        base = n_pulses;
        keys = 16'(1) << K5;
        tick(52);
        check("p5_pulses", 32'(n_pulses - base), 32'h1);
        check("p5_phex",   32'(pulse_hex),       32'h5);
        check("p5_hex",    32'(kp.key_hex),      32'h5);
        check("p5_down",   32'(kp.key_down),     32'h1);
        tick(32);
        check("p5_norep",  32'(n_pulses - base), 32'h1);
        keys = 16'h0;
        tick(16);
        check("p5_rel1",   32'(kp.key_down),     32'h1);
        tick(48);
        check("p5_rel2",   32'(kp.key_down),     32'h0);
        check("p5_relpul", 32'(n_pulses - base), 32'h1);
        check("p5_hold",   32'(kp.key_hex),      32'h5);

        // 3. Bounce on 'A', then a clean hold
        do_reset("rst1");
        align_scan();
        base = n_pulses;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? (16'(1) << KA) : 16'h0;
            tick(16);
        end
        check("bnc_pulses", 32'(n_pulses - base), 32'h0);
        check("bnc_hex",    32'(kp.key_hex),      32'hF);
        check("bnc_down",   32'(kp.key_down),     32'h0);
        keys = 16'(1) << KA;
        tick(52);
        check("pA_pulses",  32'(n_pulses - base), 32'h1);
        check("pA_hex",     32'(kp.key_hex),      32'hA);
        check("pA_down",    32'(kp.key_down),     32'h1);

        // 4. Chord, release to single, swap key while held
        keys = 16'h0;
        tick(64);
        check("ch_rel",     32'(kp.key_down),     32'h0);
        align_scan();
        base = n_pulses;
        keys = (16'(1) << K1) | (16'(1) << K9);
        tick(64);
        check("ch_nopulse", 32'(n_pulses - base), 32'h0);
        keys = 16'(1) << K1;
        tick(52);
        check("ch_p1",      32'(n_pulses - base), 32'h1);
        check("ch_p1hex",   32'(pulse_hex),       32'h1);
        keys = 16'(1) << K0;
        tick(64);
        check("sw_nopulse", 32'(n_pulses - base), 32'h1);
        check("sw_hex",     32'(kp.key_hex),      32'h1);
        check("sw_down",    32'(kp.key_down),     32'h1);
        keys = 16'h0;
        tick(64);
        check("sw_rel",     32'(kp.key_down),     32'h0);
        keys = 16'(1) << K0;
        tick(52);
        check("sw_p0",      32'(n_pulses - base), 32'h2);
        check("sw_p0hex",   32'(kp.key_hex),      32'h0);
        keys = 16'h0;
        tick(64);

        // 5. Every key of the map
        for (int i = 0; i < 16; i++) begin
            base = n_pulses;
            keys = 16'(1) << i;
            tick(52);
            check($sformatf("map%0d_pulse", i), 32'(n_pulses - base), 32'h1);
            check($sformatf("map%0d_hex", i),   32'(pulse_hex),       32'(exp_map[i]));
            keys = 16'h0;
            tick(64);
            check($sformatf("map%0d_rel", i),   32'(kp.key_down),     32'h0);
        end

        // 6. Reset during PRESS_WAIT of '7'
        align_scan();
        base = n_pulses;
        keys = 16'(1) << K7;
        tick(16);
        check("r7_pw_pulse", 32'(n_pulses - base), 32'h0);
        do_reset("rst2");
        tick(31);
        check("r7_early_v",  32'(kp.key_valid),    32'h0);
        check("r7_early_p",  32'(n_pulses - base), 32'h0);
        check("r7_early_d",  32'(kp.key_down),     32'h0);
        tick(1);
        check("r7_valid",    32'(kp.key_valid),    32'h1);
        check("r7_hex",      32'(kp.key_hex),      32'h7);
        tick(4);
        check("r7_pulses",   32'(n_pulses - base), 32'h1);
        check("r7_down",     32'(kp.key_down),     32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
